// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage HI/LO multiply/divide unit.
// Op codes match the 2-bit op field driven by the decoder.
package hilo_muldiv_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU engine owning the HI/LO pair.
// Magnitudes are iterated; the sign fix-up happens in one extra cycle.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int W2 = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic            is_div_q, is_div_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic             sgn;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [W2-1:0]    div_next;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo, rem, q_fix, r_fix;

    // Two's-complement negate of the most negative value is still its exact
    // unsigned magnitude, so the W-bit negate covers 0x80000000 correctly.
    assign sgn  = ~op[0];
    assign mag1 = (sgn && in1[WIDTH-1]) ? -in1 : in1;
    assign mag2 = (sgn && in2[WIDTH-1]) ? -in2 : in2;

    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    assign rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, opnd_q};
    assign qbit     = ~diff[WIDTH];
    assign div_next = {(qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], qbit};

    assign prod  = neg_a_q ? -acc_q : acc_q;
    assign quo   = acc_q[WIDTH-1:0];
    assign rem   = acc_q[W2-1:WIDTH];
    assign q_fix = neg_a_q ? -quo : quo;
    assign r_fix = neg_b_q ? -rem : rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    acc_d    = {{WIDTH{1'b0}}, mag1};
                    opnd_d   = mag2;
                    neg_a_d  = sgn & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                    neg_b_d  = sgn & op[1] & in1[WIDTH-1];
                    dz_d     = op[1] & (in2 == '0);
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                // Divide-by-zero leaves |in1| as remainder; restoring its
                // sign reproduces the original dividend in HI.
                if (is_div_q) begin
                    hi_d = r_fix;
                    lo_d = dz_q ? {WIDTH{1'b1}} : q_fix;
                end else begin
                    hi_d = prod[W2-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected {hi,lo} queued at start,
// compared when done pulses; directed corner cases plus a random sweep.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in1, in2;
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;
    int edges = 0;
    int e0 = 0;
    logic [63:0] sbq[$];
    logic [63:0] last_exp;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .in1(in1), .in2(in2), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sv, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sv = longint'($signed(b));
        p = '0;
        case (o)
            2'b00: p = sa * sv;
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sv;
                    r = sa % sv;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            check("done_busy_overlap", {63'b0, busy}, 64'd0);
            if (sbq.size() == 0) begin
                check("spurious_done", {63'b0, done}, 64'd0);
            end else begin
                check("result", {hi, lo}, sbq.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input logic hw, input logic [31:0] wd);
        @(negedge clk);
        start = 1'b1; op = o; in1 = a; in2 = b;
        mthi = hw; wdata = wd;
        sbq.push_back(exp);
        e0 = edges + 1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [63:0] exp);
        logic ok;
        int i;
        ok = 1'b1;
        for (i = 0; i < 40; i++) begin
            if (done) break;
            if (!busy) ok = 1'b0;
            @(negedge clk);
        end
        check({tag, "_timeout"}, {63'b0, done}, 64'd1);
        check({tag, "_busy_run"}, {63'b0, ok}, 64'd1);
        check({tag, "_busy_off"}, {63'b0, busy}, 64'd0);
        // done is registered at edge 33 counted from the accepting edge 0
        check({tag, "_lat"}, 64'(edges - e0), 64'd33);
        last_exp = exp;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        issue(o, a, b, exp, 1'b0, 32'h0);
        wait_done(tag, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic        saw;
        reset = 1'b1; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0; last_exp = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_state", {hi, lo}, 64'd0);
        check("rst_flags", {62'b0, busy, done}, 64'd0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5,
               64'hFFFF_FFFF_FFFF_FFF1);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_7_2", 2'b11, 32'd7, 32'd2, 64'h0000_0001_0000_0003);
        run_op("div_wrap", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000);
        run_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0,
               64'h1234_5678_FFFF_FFFF);
        run_op("div_zero", 2'b10, 32'hFFFF_FFFB, 32'd0,
               64'hFFFF_FFFB_FFFF_FFFF);

        // start and mthi while busy must both be dropped
        issue(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b00; in1 = 32'd5; in2 = 32'd5;
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check("hold_run", {hi, lo}, last_exp);
        wait_done("busy_ovl", 64'h0000_0002_0000_000E);

        @(negedge clk);
        mtlo = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_idle", {hi, lo}, 64'h0000_0002_CAFE_F00D);
        check("mtlo_nodone", {63'b0, done}, 64'd0);

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0001_2345;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_both", {hi, lo}, 64'h0001_2345_0001_2345);

        // accepted start beats a same-cycle mthi
        issue(2'b01, 32'd3, 32'd4, 64'h0000_0000_0000_000C,
              1'b1, 32'h0000_BEEF);
        check("start_wins_hold", {hi, lo}, 64'h0001_2345_0001_2345);
        wait_done("start_wins", 64'h0000_0000_0000_000C);

        run_op("mult_seed", 2'b00, 32'd9, 32'd11, 64'h0000_0000_0000_0063);

        // reset mid-divide: abort without a done pulse or HI/LO write
        @(negedge clk);
        start = 1'b1; op = 2'b10; in1 = 32'd1000; in2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {63'b0, busy}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_done", {63'b0, done}, 64'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        check("rst_no_done", {63'b0, saw}, 64'd0);
        run_op("after_rst", 2'b00, 32'd7, 32'hFFFF_FFFA,
               64'hFFFF_FFFF_FFFF_FFD6);

        for (int k = 0; k < 8; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (k == 3) rb = 32'd0;
            run_op("rand", ro, ra, rb, model(ro, ra, rb));
        end

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
